// File: rtl/clock_strobe_gen_if.sv
// ----------------------------------------------------------------------------
// clock_strobe_gen_if
//   Increment-update handshake bundle for clock_strobe_gen.
//   Ports (signals):
//     cfg_valid    master->slave  update request
//     cfg_ready    slave->master  update can be accepted
//     cfg_channel  master->slave  target channel, CH_W bits
//     cfg_inc      master->slave  new increment, ACC_WIDTH bits
//   Modports: master (update source), slave (clock_strobe_gen).
// ----------------------------------------------------------------------------
interface clock_strobe_gen_if #(
   parameter int CH_W      = 1,
   parameter int ACC_WIDTH = 16
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CH_W-1:0]      cfg_channel;
   logic [ACC_WIDTH-1:0] cfg_inc;

   modport master (output cfg_valid, output cfg_channel, output cfg_inc, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_channel, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/clock_strobe_gen.sv
// ----------------------------------------------------------------------------
// clock_strobe_gen
//   Multi-channel numerically-controlled clock-enable generator. Each channel
//   owns a phase accumulator whose carry-out becomes a registered one-cycle
//   strobe (rate = f_clk * inc / 2^ACC_WIDTH). Generation is gated by a
//   lock-filtered ready derived from the PLL locked flag. Increment updates
//   go through a single pending slot and land only at the target channel's
//   next carry (or at once when idle / not ready).
//   Ports:
//     clock_in   in   PLL output clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     locked     in   raw PLL lock flag (asynchronous)
//     cfg        if   clock_strobe_gen_if.slave update handshake
//     ready      out  lock-filtered run enable
//     strobe     out  per-channel one-cycle clock-enable pulses
//     square     out  (CLOCK_STROBE_SQUARE_EN only) registered accumulator MSB
//   Optional feature macro: CLOCK_STROBE_SQUARE_EN
// ----------------------------------------------------------------------------
module clock_strobe_gen #(
   parameter int CHANNELS    = 2,
   parameter int ACC_WIDTH   = 16,
   parameter int LOCK_FILTER = 1024,
   parameter logic [CHANNELS*ACC_WIDTH-1:0] INC_INIT = {CHANNELS{ACC_WIDTH'(1)}}
) (
   input  logic                clock_in,
   input  logic                reset_n,
   input  logic                locked,
   clock_strobe_gen_if.slave   cfg,
   output logic                ready,
   output logic [CHANNELS-1:0] strobe
`ifdef CLOCK_STROBE_SQUARE_EN
   ,
   output logic [CHANNELS-1:0] square
`endif
);

   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FILTER);
   localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

   // lock synchroniser and filter
   logic              r_lock_s1;
   logic              r_lock_s2;
   logic [LOCK_W-1:0] r_lock_cnt;
   logic              r_ready;
   logic [LOCK_W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_lock_cnt + 1'b1;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_lock_s1  <= 1'b0;
         r_lock_s2  <= 1'b0;
         r_lock_cnt <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_lock_s1 <= locked;
         r_lock_s2 <= r_lock_s1;
         if (!r_lock_s2) begin
            r_lock_cnt <= '0;
            r_ready    <= 1'b0;
         end else if (r_lock_cnt != LOCK_MAX) begin
            r_lock_cnt <= w_cnt_inc;
            r_ready    <= (w_cnt_inc == LOCK_MAX);
         end else begin
            r_ready    <= 1'b1;
         end
      end
   end

   // accumulators, increments and the pending update slot
   logic [ACC_WIDTH-1:0] r_acc [CHANNELS];
   logic [ACC_WIDTH-1:0] r_inc [CHANNELS];
   logic [CHANNELS-1:0]  r_strobe;
   logic                 r_pend_v;
   logic [CH_W-1:0]      r_pend_ch;
   logic [ACC_WIDTH-1:0] r_pend_inc;
   logic [ACC_WIDTH:0]   w_sum [CHANNELS];
   logic [CHANNELS-1:0]  w_carry;
   logic                 w_apply;

   // w_apply is only meaningful while r_pend_v is set; it selects the
   // pending channel's release condition without indexing past CHANNELS.
   always_comb begin
      w_apply = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
         w_carry[i] = r_ready & w_sum[i][ACC_WIDTH];
         if (r_pend_ch == CH_W'(i))
            w_apply = ~r_ready | (r_inc[i] == '0) | w_carry[i];
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_acc[i] <= '0;
            r_inc[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
         end
         r_strobe   <= '0;
         r_pend_v   <= 1'b0;
         r_pend_ch  <= '0;
         r_pend_inc <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (r_ready) begin
               r_acc[i]    <= w_sum[i][ACC_WIDTH-1:0];
               r_strobe[i] <= w_carry[i];
            end else begin
               r_acc[i]    <= '0;
               r_strobe[i] <= 1'b0;
            end
            // the add on this edge still uses the old increment
            if (r_pend_v && w_apply && (r_pend_ch == CH_W'(i)))
               r_inc[i] <= r_pend_inc;
         end
         if (r_pend_v) begin
            if (w_apply)
               r_pend_v <= 1'b0;
         end else if (cfg.cfg_valid) begin
            // out-of-range channels are accepted but never occupy the slot
            if ({1'b0, cfg.cfg_channel} < CH_LIMIT) begin
               r_pend_v   <= 1'b1;
               r_pend_ch  <= cfg.cfg_channel;
               r_pend_inc <= cfg.cfg_inc;
            end
         end
      end
   end

   assign ready         = r_ready;
   assign strobe        = r_strobe;
   assign cfg.cfg_ready = ~r_pend_v;

`ifdef CLOCK_STROBE_SQUARE_EN
   logic [CHANNELS-1:0] r_square;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_square <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++)
            r_square[i] <= r_ready & r_acc[i][ACC_WIDTH-1];
      end
   end

   assign square = r_square;
`endif

endmodule

// File: tb/tb_clock_strobe_gen.sv
// ----------------------------------------------------------------------------
// tb_clock_strobe_gen
//   Bench for clock_strobe_gen (CHANNELS=2, ACC_WIDTH=8, LOCK_FILTER=4,
//   INC_INIT={128,64}). A behavioural model tracks lock run lengths, integer
//   accumulators and a one-entry update slot; it is compared against the DUT
//   every cycle. Directed phases pin absolute timings with literals; a second
//   3-channel instance covers an unrepresentable-in-2ch out-of-range channel.
// ----------------------------------------------------------------------------
module tb_clock_strobe_gen;
   localparam int LF = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       locked;
   logic       ready;
   logic       ready3;
   logic [1:0] strobe;
   logic [2:0] strobe3;
`ifdef CLOCK_STROBE_SQUARE_EN
   logic [1:0] square;
   logic [2:0] square3;
`endif

   clock_strobe_gen_if #(.CH_W(1), .ACC_WIDTH(8)) cfg_if ();
   clock_strobe_gen_if #(.CH_W(2), .ACC_WIDTH(8)) cfg3_if ();

   clock_strobe_gen #(
      .CHANNELS(2), .ACC_WIDTH(8), .LOCK_FILTER(LF), .INC_INIT(16'h80_40)
   ) u_dut (
      .clock_in(clk), .reset_n(reset_n), .locked(locked), .cfg(cfg_if),
      .ready(ready), .strobe(strobe)
`ifdef CLOCK_STROBE_SQUARE_EN
      , .square(square)
`endif
   );

   clock_strobe_gen #(
      .CHANNELS(3), .ACC_WIDTH(8), .LOCK_FILTER(LF), .INC_INIT(24'h20_80_40)
   ) u_dut3 (
      .clock_in(clk), .reset_n(reset_n), .locked(locked), .cfg(cfg3_if),
      .ready(ready3), .strobe(strobe3)
`ifdef CLOCK_STROBE_SQUARE_EN
      , .square(square3)
`endif
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_run0, m_run1;   // consecutive locked samples ending 1 and 2 edges ago
   bit       m_ready;
   int       m_acc [2];
   int       m_inc [2];
   int       m_sum;
   bit [1:0] m_cy, m_str, m_sq;
   bit       m_pv;
   int       m_pch, m_pinc;
   bit       s_l, s_v;
   int       s_ch, s_inc;

   initial begin
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_run0 = 0; m_run1 = 0; m_ready = 0;
            m_acc = '{0, 0}; m_inc = '{64, 128};
            m_str = '0; m_sq = '0; m_pv = 0;
         end else begin
            s_l   = locked;
            s_v   = cfg_if.cfg_valid;
            s_ch  = int'(cfg_if.cfg_channel);
            s_inc = int'(cfg_if.cfg_inc);
            for (int c = 0; c < 2; c++) begin
               m_sum   = m_acc[c] + m_inc[c];
               m_cy[c] = m_ready && (m_sum >= 256);
               if (m_ready) begin
                  m_sq[c]  = (m_acc[c] >= 128);
                  m_acc[c] = m_sum % 256;
                  m_str[c] = m_cy[c];
               end else begin
                  m_sq[c]  = 0;
                  m_acc[c] = 0;
                  m_str[c] = 0;
               end
            end
            if (m_pv) begin
               if (!m_ready || m_inc[m_pch] == 0 || m_cy[m_pch]) begin
                  m_inc[m_pch] = m_pinc;
                  m_pv = 0;
               end
            end else if (s_v && s_ch < 2) begin
               m_pv = 1; m_pch = s_ch; m_pinc = s_inc;
            end
            m_ready = (m_run1 >= LF);
            m_run1  = m_run0;
            m_run0  = s_l ? ((m_run0 < LF) ? m_run0 + 1 : LF) : 0;
         end
         #1;
         chk("model_ready", int'(ready), int'(m_ready));
         chk("model_strobe", int'(strobe), int'(m_str));
         chk("model_cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pv));
`ifdef CLOCK_STROBE_SQUARE_EN
         chk("model_square", int'(square), int'(m_sq));
`endif
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_sig(input int sel, input int budget, output int at);
      bit hit;
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #1;
         case (sel)
            0: hit = ready;
            1: hit = !ready;
            2: hit = strobe[0];
            3: hit = strobe[1];
            4: hit = strobe3[0];
            5: hit = strobe3[2];
            default: hit = 0;
         endcase
         if (hit) begin
            at = cyc;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int t0, d, a, e1, sA, accB, f, at, at2, n, drop_cnt;
   bit prev_rdy;

   initial begin
      reset_n = 1'b0; locked = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_channel = '0; cfg_if.cfg_inc = '0;
      cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_channel = '0; cfg3_if.cfg_inc = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(ready), 0);
      chk("rst_strobe", int'(strobe), 0);
      chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);

      // 1. lock filter timing and first aligned strobes
      #1; reset_n = 1'b1; locked = 1'b1; t0 = cyc;
      wait_sig(0, 20, at);  chk("ready_rise", at - t0, 6);
      wait_sig(3, 20, at);  chk("first_strobe1", at - t0, 8);
      wait_sig(2, 20, at);  chk("first_strobe0", at - t0, 10);
      wait_sig(2, 20, at);  chk("strobe0_period", at - t0, 14);

      // 2. short lock drop restarts the filter
      d = cyc;
      #1; locked = 1'b0;
      fork
         begin repeat (2) @(posedge clk); #2; locked = 1'b1; end
      join_none
      wait_sig(1, 3, at);   chk("ready_drop", at - d, 3);
      wait_sig(0, 20, at);  chk("relock_ready", at - d, 8);
      wait_sig(3, 20, at);  chk("relock_strobe1", at - d, 10);
      wait_sig(2, 20, at);  chk("relock_strobe0", at - d, 12);

      // 3. ch0 increment change lands at the next carry
      a = cyc;
      #1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_channel = 1'b0; cfg_if.cfg_inc = 8'd32;
      @(posedge clk); #1;
      chk("cfg_busy", int'(cfg_if.cfg_ready), 0);
      cfg_if.cfg_valid = 1'b0;
      wait_sig(2, 20, at);  chk("old_spacing", at - a, 4);
      chk("cfg_free_at_carry", int'(cfg_if.cfg_ready), 1);
      wait_sig(2, 20, at);  chk("new_spacing", at - a, 12);

      // 4. second update held off until the first applies
      #1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_channel = 1'b0; cfg_if.cfg_inc = 8'd64;
      @(posedge clk); #1;
      e1 = cyc;
      chk("first_pending", int'(cfg_if.cfg_ready), 0);
      cfg_if.cfg_channel = 1'b1; cfg_if.cfg_inc = 8'd0;
      sA = -1000; accB = -1000; prev_rdy = cfg_if.cfg_ready;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (prev_rdy) begin
            accB = cyc;
            break;
         end
         if (strobe[0]) sA = cyc;
         prev_rdy = cfg_if.cfg_ready;
      end
      cfg_if.cfg_valid = 1'b0;
      chk("first_apply", sA - e1, 7);
      chk("second_accept", accB - sA, 1);
      chk("second_pending", int'(cfg_if.cfg_ready), 0);
      @(posedge clk); #1;
      chk("second_applied", int'(cfg_if.cfg_ready), 1);

      // 5. ch1 silent at inc=0, then inc=1 applies at once
      n = 0;
      repeat (20) begin @(posedge clk); #1; if (strobe[1]) n++; end
      chk("ch1_silent", n, 0);
      #1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_channel = 1'b1; cfg_if.cfg_inc = 8'd1;
      @(posedge clk); #1;
      f = cyc;
      chk("imm_pending", int'(cfg_if.cfg_ready), 0);
      cfg_if.cfg_valid = 1'b0;
      @(posedge clk); #1;
      chk("imm_apply", int'(cfg_if.cfg_ready), 1);
      wait_sig(3, 300, at);  chk("slow_first", at - f, 257);
      wait_sig(3, 300, at2); chk("slow_period", at2 - at, 256);

      // 6. asynchronous reset mid-strobe, INC_INIT restored, out-of-range cfg
      wait_sig(2, 10, at);
      chk("pre_reset_strobe", int'(strobe[0]), 1);
      #2; reset_n = 1'b0;
      #1;
      chk("async_ready", int'(ready), 0);
      chk("async_strobe", int'(strobe), 0);
      chk("async_cfg_ready", int'(cfg_if.cfg_ready), 1);
`ifdef CLOCK_STROBE_SQUARE_EN
      chk("async_square", int'(square), 0);
`endif
      repeat (2) @(posedge clk);
      #2; reset_n = 1'b1; t0 = cyc;
      wait_sig(0, 20, at);  chk("rst2_ready", at - t0, 6);
      wait_sig(3, 20, at);  chk("rst2_strobe1", at - t0, 8);
      wait_sig(2, 20, at);  chk("rst2_strobe0", at - t0, 10);
      #1; cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_channel = 2'd3; cfg3_if.cfg_inc = 8'd5;
      @(posedge clk); #1;
      chk("oor_cfg_ready", int'(cfg3_if.cfg_ready), 1);
      cfg3_if.cfg_valid = 1'b0;
      wait_sig(4, 20, at);  wait_sig(4, 20, at2); chk("oor_ch0_period", at2 - at, 4);
      wait_sig(5, 20, at);  wait_sig(5, 20, at2); chk("oor_ch2_period", at2 - at, 8);
      chk("oor_ready3", int'(ready3), 1);

      // 7. randomized traffic against the model
      drop_cnt = 0;
      repeat (3000) begin
         @(posedge clk); #2;
         if (drop_cnt > 0) begin
            locked = 1'b0;
            drop_cnt--;
         end else begin
            locked = 1'b1;
            if ($urandom_range(0, 149) == 0) drop_cnt = $urandom_range(1, 6);
         end
         cfg_if.cfg_valid   = ($urandom_range(0, 2) == 0);
         cfg_if.cfg_channel = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: cfg_if.cfg_inc = 8'd0;
            1: cfg_if.cfg_inc = 8'd1;
            2: cfg_if.cfg_inc = 8'd128;
            3: cfg_if.cfg_inc = 8'd64;
            4: cfg_if.cfg_inc = 8'd255;
            default: cfg_if.cfg_inc = 8'($urandom_range(0, 255));
         endcase
      end
      cfg_if.cfg_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
